// File: rtl/prog_loader_if.sv
// Byte-stream and program-memory write bus used by the program loader.
//   byte_valid/byte_data : stream source -> loader, transfer on valid && ready
//   byte_ready           : loader -> source
//   mem_we/addr/wdata    : loader -> program memory, one strobe per word
// master: the side that feeds the byte stream and observes the memory writes.
// slave:  the loader.
interface prog_loader_if;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 16;

    logic              byte_valid;
    logic [7:0]        byte_data;
    logic              byte_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;

    modport master (
        output byte_valid,
        output byte_data,
        input  byte_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

    modport slave (
        input  byte_valid,
        input  byte_data,
        output byte_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader: packs a byte stream into 16-bit words, writes them into the
// 64x16 instruction store, then checks an 8-bit additive checksum trailer.
// The cpu is held in reset from the start of a load until it passes.
// Ports:
//   clk        rising-edge clock
//   reset      async active-low reset
//   start      1-cycle pulse, begins a load of len words (ignored while busy)
//   len        word count 1..64, sampled on start
//   bus        byte stream in, memory write strobe/address/data out
//   cpu_reset  active-high reset to the cpu
//   busy       load in progress
//   done       load finished (pass or fail), held until the next start
//   err        checksum mismatch or illegal len, valid while done=1
module prog_loader (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [6:0]   len,
    prog_loader_if.slave bus,
    output logic         cpu_reset,
    output logic         busy,
    output logic         done,
    output logic         err
);
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_WR,
        S_CSUM,
        S_DONE
    } state_t;

    state_t            r_state;
    state_t            w_state_nx;
    logic [CNT_W-1:0]  r_len;
    logic [CNT_W-1:0]  w_len_nx;
    logic [CNT_W-1:0]  r_count;
    logic [CNT_W-1:0]  w_count_nx;
    logic [CNT_W-1:0]  w_count_inc;
    logic [7:0]        r_hi;
    logic [7:0]        w_hi_nx;
    logic [7:0]        r_csum;
    logic [7:0]        w_csum_nx;
    logic              r_byte_ready;
    logic              w_byte_ready_nx;
    logic              r_mem_we;
    logic              w_mem_we_nx;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [ADDR_W-1:0] w_mem_addr_nx;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] w_mem_wdata_nx;
    logic              r_cpu_reset;
    logic              w_cpu_reset_nx;
    logic              r_busy;
    logic              w_busy_nx;
    logic              r_done;
    logic              w_done_nx;
    logic              r_err;
    logic              w_err_nx;
    logic              w_xfer;
    logic              w_len_ok;

    // byte_ready is a register that tracks the state, so it is a valid handshake qualifier
    assign w_xfer      = bus.byte_valid && r_byte_ready;
    assign w_len_ok    = (len != CNT_W'(0)) && (len <= CNT_W'(DEPTH));
    assign w_count_inc = r_count + CNT_W'(1);

    // Next-state and next-output logic
    always_comb begin
        w_state_nx     = r_state;
        w_len_nx       = r_len;
        w_count_nx     = r_count;
        w_hi_nx        = r_hi;
        w_csum_nx      = r_csum;
        w_mem_addr_nx  = r_mem_addr;
        w_mem_wdata_nx = r_mem_wdata;
        w_err_nx       = r_err;

        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    if (w_len_ok) begin
                        w_state_nx    = S_HI;
                        w_len_nx      = len;
                        w_count_nx    = '0;
                        w_csum_nx     = '0;
                        w_mem_addr_nx = '0;
                        w_err_nx      = 1'b0;
                    end else begin
                        w_state_nx = S_DONE;
                        w_err_nx   = 1'b1;
                    end
                end
            end
            S_HI: begin
                if (w_xfer) begin
                    w_hi_nx    = bus.byte_data;
                    w_csum_nx  = r_csum + bus.byte_data;
                    w_state_nx = S_LO;
                end
            end
            S_LO: begin
                if (w_xfer) begin
                    w_csum_nx      = r_csum + bus.byte_data;
                    w_mem_wdata_nx = {r_hi, bus.byte_data};
                    w_mem_addr_nx  = ADDR_W'(r_count);
                    w_state_nx     = S_WR;
                end
            end
            S_WR: begin
                // 7-bit count so len=64 terminates at 64 instead of wrapping to 0
                w_count_nx = w_count_inc;
                w_state_nx = (w_count_inc == r_len) ? S_CSUM : S_HI;
            end
            S_CSUM: begin
                if (w_xfer) begin
                    w_err_nx   = (bus.byte_data != r_csum);
                    w_state_nx = S_DONE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        // Outputs are registered copies of what the next state implies
        w_byte_ready_nx = (w_state_nx inside {S_HI, S_LO, S_CSUM});
        w_mem_we_nx     = (w_state_nx == S_WR);
        w_busy_nx       = (w_state_nx inside {S_HI, S_LO, S_WR, S_CSUM});
        w_done_nx       = (w_state_nx == S_DONE);
        w_cpu_reset_nx  = (w_state_nx == S_DONE) ? w_err_nx : 1'b1;
    end

    // State and output registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_len        <= '0;
            r_count      <= '0;
            r_hi         <= '0;
            r_csum       <= '0;
            r_byte_ready <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_reset  <= 1'b1;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_state      <= w_state_nx;
            r_len        <= w_len_nx;
            r_count      <= w_count_nx;
            r_hi         <= w_hi_nx;
            r_csum       <= w_csum_nx;
            r_byte_ready <= w_byte_ready_nx;
            r_mem_we     <= w_mem_we_nx;
            r_mem_addr   <= w_mem_addr_nx;
            r_mem_wdata  <= w_mem_wdata_nx;
            r_cpu_reset  <= w_cpu_reset_nx;
            r_busy       <= w_busy_nx;
            r_done       <= w_done_nx;
            r_err        <= w_err_nx;
        end
    end

    assign bus.byte_ready = r_byte_ready;
    assign bus.mem_we     = r_mem_we;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign cpu_reset      = r_cpu_reset;
    assign busy           = r_busy;
    assign done           = r_done;
    assign err            = r_err;

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: loads push expected writes/outcomes,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_prog_loader;
    logic       clk;
    logic       reset;
    logic       start;
    logic [6:0] len;
    logic       cpu_reset;
    logic       busy;
    logic       done;
    logic       err;

    prog_loader_if bus();

    prog_loader dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .len       (len),
        .bus       (bus),
        .cpu_reset (cpu_reset),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    typedef struct {
        logic [5:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t         exp_wr[$];
    logic        exp_done[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          cyc_start = 0;
    int          done_cyc = 0;
    int          n_writes = 0;
    logic        done_q = 1'b0;
    logic        we_q = 1'b0;
    logic [7:0]  bytes_buf[128];
    logic [15:0] act_mem[64];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: sim time limit reached, bad=%0d", bad);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every memory write and every completed load
    always @(negedge clk) begin
        wr_t  e;
        logic e_err;
        if (bus.mem_we) begin
            check("we_single_cycle", 32'(we_q), 32'd0);
            if (exp_wr.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr=%0h data=%0h, expected no write", bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_wr.pop_front();
                check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                check("wr_data", 32'(bus.mem_wdata), 32'(e.data));
            end
            act_mem[bus.mem_addr] = bus.mem_wdata;
            n_writes++;
        end
        if (done && !done_q) begin
            done_cyc = cyc;
            if (exp_done.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: err=%0b, expected no completion", err);
            end else begin
                e_err = exp_done.pop_front();
                check("done_err", 32'(err), 32'(e_err));
                check("done_cpu_reset", 32'(cpu_reset), 32'(e_err));
                check("done_busy", 32'(busy), 32'd0);
            end
        end
        done_q = done;
        we_q   = bus.mem_we;
    end

    task automatic do_start(input int n);
        @(posedge clk);
        #1;
        start     = 1'b1;
        len       = 7'(n);
        cyc_start = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Offer one byte after a random idle gap; bounded wait for the handshake
    task automatic send_byte(input logic [7:0] b, input int gap_max);
        int   n;
        int   waited;
        logic hs;
        n = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (n) begin
            bus.byte_valid = 1'b0;
            bus.byte_data  = 8'($urandom);
            @(posedge clk);
            #1;
        end
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        waited = 0;
        forever begin
            hs = bus.byte_ready;
            @(posedge clk);
            #1;
            if (hs) break;
            waited++;
            if (waited > 100) begin
                total++;
                bad++;
                $display("FAIL byte_handshake_timeout: byte %0h not accepted, expected ready", b);
                break;
            end
        end
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while (!done && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        @(negedge clk);
        #1;
        check("done_seen", 32'(done), 32'd1);
    endtask

    // Full load of n words from bytes_buf; checksum computed from the byte sum
    task automatic run_load(input int n, input logic [7:0] trailer, input int gap, input bit mid_start);
        int         sum;
        logic [7:0] csum;
        sum = 0;
        for (int i = 0; i < 2 * n; i++) sum += int'(bytes_buf[i]);
        csum = 8'(sum % 256);
        exp_done.push_back(trailer != csum);
        do_start(n);
        check("load_busy", 32'(busy), 32'd1);
        check("load_cpu_reset", 32'(cpu_reset), 32'd1);
        check("load_done_clr", 32'(done), 32'd0);
        check("load_err_clr", 32'(err), 32'd0);
        if (mid_start) begin
            fork
                begin
                    repeat (4) @(posedge clk);
                    #1;
                    start = 1'b1;
                    len   = 7'd5;
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end
            join_none
        end
        for (int i = 0; i < n; i++) begin
            wr_t w;
            w.addr = 6'(i);
            w.data = {bytes_buf[2*i], bytes_buf[2*i+1]};
            exp_wr.push_back(w);
            send_byte(bytes_buf[2*i], gap);
            send_byte(bytes_buf[2*i+1], gap);
        end
        send_byte(trailer, gap);
        bus.byte_valid = 1'b0;
        wait_done();
    endtask

    initial begin
        int nw0;
        reset          = 1'b0;
        start          = 1'b0;
        len            = '0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ready", 32'(bus.byte_ready), 32'd0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
        reset = 1'b1;

        // Basic two-word load, good trailer
        bytes_buf[0] = 8'h12; bytes_buf[1] = 8'h34; bytes_buf[2] = 8'hAB; bytes_buf[3] = 8'hCD;
        nw0 = n_writes;
        run_load(2, 8'hBE, 0, 1'b0);
        check("t1_mem0", 32'(act_mem[0]), 32'h1234);
        check("t1_mem1", 32'(act_mem[1]), 32'hABCD);
        check("t1_nwrites", 32'(n_writes - nw0), 32'd2);
        check("t1_cpu_reset", 32'(cpu_reset), 32'd0);
        check("t1_err", 32'(err), 32'd0);

        // Bad trailer
        run_load(2, 8'hBF, 0, 1'b0);
        check("t2_err", 32'(err), 32'd1);
        check("t2_cpu_reset", 32'(cpu_reset), 32'd1);

        // Full 64-word load, valid held high, incrementing bytes
        for (int i = 0; i < 128; i++) bytes_buf[i] = 8'(i);
        nw0 = n_writes;
        run_load(64, 8'(((127 * 128) / 2) % 256), 0, 1'b0);
        check("t3_nwrites", 32'(n_writes - nw0), 32'd64);
        check("t3_latency", 32'(done_cyc - cyc_start), 32'd194);
        check("t3_err", 32'(err), 32'd0);

        // Illegal lengths from DONE: immediate error, no writes, no ready
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h5A;
        nw0 = n_writes;
        do_start(0);
        check("t4a_done", 32'(done), 32'd1);
        check("t4a_err", 32'(err), 32'd1);
        check("t4a_busy", 32'(busy), 32'd0);
        check("t4a_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t4a_ready", 32'(bus.byte_ready), 32'd0);
        do_start(65);
        check("t4b_done", 32'(done), 32'd1);
        check("t4b_err", 32'(err), 32'd1);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("t4_ready_low", 32'(bus.byte_ready), 32'd0);
        end
        check("t4_nwrites", 32'(n_writes - nw0), 32'd0);
        bus.byte_valid = 1'b0;

        // Random valid gaps, same image as the basic load
        bytes_buf[0] = 8'h12; bytes_buf[1] = 8'h34; bytes_buf[2] = 8'hAB; bytes_buf[3] = 8'hCD;
        run_load(2, 8'hBE, 3, 1'b0);
        check("t5_mem0", 32'(act_mem[0]), 32'h1234);
        check("t5_mem1", 32'(act_mem[1]), 32'hABCD);
        check("t5_err", 32'(err), 32'd0);

        // Reset after the third byte of a new load
        begin
            wr_t w;
            w.addr = 6'd0;
            w.data = 16'h1122;
            exp_wr.push_back(w);
        end
        do_start(2);
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        send_byte(8'h33, 1);
        nw0 = n_writes;
        reset = 1'b0;
        #1;
        check("t5r_cpu_reset", 32'(cpu_reset), 32'd1);
        check("t5r_busy", 32'(busy), 32'd0);
        check("t5r_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            check("t5r_ready_low", 32'(bus.byte_ready), 32'd0);
        end
        check("t5r_nwrites", 32'(n_writes - nw0), 32'd0);
        bus.byte_valid = 1'b0;

        // Start pulsed mid-load is ignored; then a failing load followed by a re-run from DONE
        for (int i = 0; i < 6; i++) bytes_buf[i] = 8'($urandom);
        nw0 = n_writes;
        run_load(3, 8'(int'(bytes_buf[0]) + int'(bytes_buf[1]) + int'(bytes_buf[2]) +
                       int'(bytes_buf[3]) + int'(bytes_buf[4]) + int'(bytes_buf[5])), 0, 1'b1);
        check("t6_nwrites", 32'(n_writes - nw0), 32'd3);
        check("t6_err", 32'(err), 32'd0);
        bytes_buf[0] = 8'h01; bytes_buf[1] = 8'h02;
        run_load(1, 8'h00, 1, 1'b0);
        check("t6_fail_err", 32'(err), 32'd1);
        bytes_buf[0] = 8'hF0; bytes_buf[1] = 8'h20;
        run_load(1, 8'h10, 1, 1'b0);
        check("t6_rerun_err", 32'(err), 32'd0);
        check("t6_rerun_cpu_reset", 32'(cpu_reset), 32'd0);

        // Randomized loads, some with corrupted trailers
        for (int k = 0; k < 6; k++) begin
            int         n;
            int         sum;
            logic [7:0] tr;
            n   = int'($urandom_range(64, 1));
            sum = 0;
            for (int i = 0; i < 2 * n; i++) begin
                bytes_buf[i] = 8'($urandom);
                sum += int'(bytes_buf[i]);
            end
            tr = 8'(sum % 256);
            if ($urandom_range(1, 0) == 1) tr = tr ^ 8'(1 << $urandom_range(7, 0));
            nw0 = n_writes;
            run_load(n, tr, 2, 1'b0);
            check("rnd_nwrites", 32'(n_writes - nw0), 32'(n));
        end

        repeat (3) @(posedge clk);
        check("exp_wr_drained", 32'(exp_wr.size()), 32'd0);
        check("exp_done_drained", 32'(exp_done.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
